// File: rtl/axi_ram_slave.sv
// AXI4 RAM slave: independent write (AW/W/B) and read (AR/R) engines over a word array.
// Supports FIXED/INCR/WRAP bursts, byte strobes and ID echo; responses are always OKAY.
module axi_ram_slave #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int unsigned LSB       = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_WIDTH = ADDR_WIDTH - LSB;
    localparam int unsigned DEPTH     = 1 << IDX_WIDTH;

    typedef enum logic [1:0] {W_IDLE, W_BURST, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_BURST}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t              w_state;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic [7:0]            w_cnt;

    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [7:0]            r_cnt;

    logic                  w_fire_c;
    logic [ADDR_WIDTH-1:0] r_next_c;
    logic                  unused_inputs;

    // Burst address step; reserved burst type falls through to INCR.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] mask;
        incr = ADDR_WIDTH'(1) << size;
        mask = ADDR_WIDTH'(((32'(len) + 32'd1) << size) - 32'd1);
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~mask) | ((addr + incr) & mask);
            default: next_addr = addr + incr;
        endcase
    endfunction

    function automatic logic [IDX_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        word_idx = addr[ADDR_WIDTH-1:LSB];
    endfunction

    assign w_fire_c      = (w_state == W_BURST) && s_axi_wvalid && s_axi_wready;
    assign r_next_c      = next_addr(r_addr, r_len, r_size, r_burst);
    assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_wlast,
                             s_axi_arlock, s_axi_arcache, s_axi_arprot};

    // Byte-lane write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_fire_c) begin
            for (int b = 0; b < int'(STRB_WIDTH); b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[word_idx(w_addr)][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Write engine: the beat count alone decides the last beat, wlast is not trusted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= 2'b00;
            w_id          <= '0;
            w_addr        <= '0;
            w_len         <= '0;
            w_size        <= '0;
            w_burst       <= '0;
            w_cnt         <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    s_axi_awready <= 1'b1;
                    if (s_axi_awvalid && s_axi_awready) begin
                        w_id          <= s_axi_awid;
                        w_addr        <= s_axi_awaddr;
                        w_len         <= s_axi_awlen;
                        w_size        <= s_axi_awsize;
                        w_burst       <= s_axi_awburst;
                        w_cnt         <= '0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_BURST;
                    end
                end
                W_BURST: begin
                    if (w_fire_c) begin
                        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                        w_cnt  <= w_cnt + 8'd1;
                        if (w_cnt == w_len) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bid    <= w_id;
                            s_axi_bresp  <= 2'b00;
                            w_state      <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read engine: next beat is fetched on the accepting edge so bursts stream without bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rresp   <= 2'b00;
            s_axi_rdata   <= '0;
            r_addr        <= '0;
            r_len         <= '0;
            r_size        <= '0;
            r_burst       <= '0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (s_axi_arvalid && s_axi_arready) begin
                        r_addr        <= s_axi_araddr;
                        r_len         <= s_axi_arlen;
                        r_size        <= s_axi_arsize;
                        r_burst       <= s_axi_arburst;
                        r_cnt         <= '0;
                        s_axi_rdata   <= mem[word_idx(s_axi_araddr)];
                        s_axi_rid     <= s_axi_arid;
                        s_axi_rresp   <= 2'b00;
                        s_axi_rlast   <= (s_axi_arlen == 8'd0);
                        s_axi_rvalid  <= 1'b1;
                        s_axi_arready <= 1'b0;
                        r_state       <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (s_axi_rvalid && s_axi_rready) begin
                        if (s_axi_rlast) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            r_addr      <= r_next_c;
                            r_cnt       <= r_cnt + 8'd1;
                            s_axi_rdata <= mem[word_idx(r_next_c)];
                            s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed and randomized bench for axi_ram_slave against a byte-addressed reference model.
module tb_axi_ram_slave;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
    localparam int unsigned SW = 4;
    localparam int unsigned IW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] s_axi_awid;
    logic [AW-1:0] s_axi_awaddr;
    logic [7:0]    s_axi_awlen;
    logic [2:0]    s_axi_awsize;
    logic [1:0]    s_axi_awburst;
    logic          s_axi_awvalid;
    logic          s_axi_awready;
    logic [DW-1:0] s_axi_wdata;
    logic [SW-1:0] s_axi_wstrb;
    logic          s_axi_wlast;
    logic          s_axi_wvalid;
    logic          s_axi_wready;
    logic [IW-1:0] s_axi_bid;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready;
    logic [IW-1:0] s_axi_arid;
    logic [AW-1:0] s_axi_araddr;
    logic [7:0]    s_axi_arlen;
    logic [2:0]    s_axi_arsize;
    logic [1:0]    s_axi_arburst;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [IW-1:0] s_axi_rid;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast;
    logic          s_axi_rvalid;
    logic          s_axi_rready;

    axi_ram_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(1'b0),
        .s_axi_awcache(4'h0), .s_axi_awprot(3'h0), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
        .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arlock(1'b0), .s_axi_arcache(4'h0), .s_axi_arprot(3'h0),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mb [int unsigned];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] got [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte address of beat i, straight from the burst definitions.
    function automatic int unsigned beat_addr(input int unsigned a, input int len, input int size,
                                              input int burst, input int i);
        int unsigned inc   = 32'd1 << size;
        int unsigned total = 32'(len + 1) * inc;
        int unsigned base;
        case (burst)
            0: return a;
            2: begin
                base = (a / total) * total;
                return base + ((a - base + 32'(i) * inc) % total);
            end
            default: return (a + 32'(i) * inc) & 32'hFFFF;
        endcase
    endfunction

    function automatic int unsigned word_base(input int unsigned a);
        return ((a >> 2) & 32'h3FFF) << 2;
    endfunction

    function automatic logic [31:0] model_word(input int unsigned a);
        int unsigned b = word_base(a);
        model_word = '0;
        for (int l = 0; l < 4; l++)
            if (mb.exists(b + 32'(l))) model_word[l*8 +: 8] = mb[b + 32'(l)];
    endfunction

    function automatic logic [31:0] model_mask(input int unsigned a);
        int unsigned b = word_base(a);
        model_mask = '0;
        for (int l = 0; l < 4; l++)
            if (mb.exists(b + 32'(l))) model_mask[l*8 +: 8] = 8'hFF;
    endfunction

    task automatic do_write(input logic [7:0] id, input int unsigned addr, input int len,
                            input int size, input int burst, input bit early_last, input int bhold);
        int t;
        int unsigned a;
        s_axi_awid = id; s_axi_awaddr = AW'(addr); s_axi_awlen = 8'(len);
        s_axi_awsize = 3'(size); s_axi_awburst = 2'(burst); s_axi_awvalid = 1'b1;
        t = 0;
        while (!s_axi_awready && t < 50) begin @(posedge clk); #1; t++; end
        check("aw_accept_timeout", 64'(t < 50), 64'(1));
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        check("awready_after_aw", 64'(s_axi_awready), 64'(0));
        check("wready_after_aw", 64'(s_axi_wready), 64'(1));
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_axi_wvalid = 1'b0;
                @(posedge clk); #1;
            end
            s_axi_wvalid = 1'b1; s_axi_wdata = wd[i]; s_axi_wstrb = ws[i];
            s_axi_wlast = early_last ? (i == 0) : (i == len);
            t = 0;
            while (!s_axi_wready && t < 50) begin @(posedge clk); #1; t++; end
            check("w_accept_timeout", 64'(t < 50), 64'(1));
            @(posedge clk); #1;
            a = beat_addr(addr, len, size, burst, i);
            for (int l = 0; l < 4; l++)
                if (ws[i][l]) mb[word_base(a) + 32'(l)] = wd[i][l*8 +: 8];
            check("bvalid_after_beat", 64'(s_axi_bvalid), 64'(i == len));
            check("wready_after_beat", 64'(s_axi_wready), 64'(i != len));
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        check("bid", 64'(s_axi_bid), 64'(id));
        check("bresp", 64'(s_axi_bresp), 64'(0));
        repeat (bhold) begin
            @(posedge clk); #1;
            check("bvalid_hold", 64'(s_axi_bvalid), 64'(1));
            check("awready_hold", 64'(s_axi_awready), 64'(0));
        end
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        check("bvalid_after_b", 64'(s_axi_bvalid), 64'(0));
        check("awready_after_b", 64'(s_axi_awready), 64'(1));
    endtask

    // mode 0: rready held high, 1: toggling, 2: random.
    task automatic do_read(input logic [7:0] id, input int unsigned addr, input int len,
                           input int size, input int burst, input int mode);
        int t;
        int cyc;
        int beat;
        int first;
        int last_hs;
        int unsigned a;
        logic [31:0] m;
        got.delete();
        s_axi_arid = id; s_axi_araddr = AW'(addr); s_axi_arlen = 8'(len);
        s_axi_arsize = 3'(size); s_axi_arburst = 2'(burst); s_axi_arvalid = 1'b1;
        t = 0;
        while (!s_axi_arready && t < 50) begin @(posedge clk); #1; t++; end
        check("ar_accept_timeout", 64'(t < 50), 64'(1));
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        check("arready_after_ar", 64'(s_axi_arready), 64'(0));
        s_axi_rready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        beat = 0; cyc = 0; first = -1; last_hs = -1;
        while (beat <= len && cyc < 400) begin
            if (s_axi_rvalid) begin
                a = beat_addr(addr, len, size, burst, beat);
                m = model_mask(a);
                check("rdata", 64'(s_axi_rdata & m), 64'(model_word(a) & m));
                check("rid", 64'(s_axi_rid), 64'(id));
                check("rresp", 64'(s_axi_rresp), 64'(0));
                check("rlast", 64'(s_axi_rlast), 64'(beat == len));
                if (first < 0) first = cyc;
                if (s_axi_rready) begin
                    got.push_back(s_axi_rdata);
                    if (beat == len) last_hs = cyc;
                    beat++;
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (mode == 1) s_axi_rready = ~s_axi_rready;
            else if (mode == 2) s_axi_rready = 1'($urandom_range(0, 1));
        end
        s_axi_rready = 1'b0;
        check("r_burst_timeout", 64'(beat), 64'(len + 1));
        check("rvalid_after_last", 64'(s_axi_rvalid), 64'(0));
        check("arready_after_last", 64'(s_axi_arready), 64'(1));
        if (mode == 0) check("r_back_to_back", 64'(last_hs - first), 64'(len));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a;
        int sz;
        int bu;
        int ln;
        logic [31:0] m;
        rst_n = 1'b0;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 64'(s_axi_awready), 64'(0));
        check("rst_wready", 64'(s_axi_wready), 64'(0));
        check("rst_bvalid", 64'(s_axi_bvalid), 64'(0));
        check("rst_arready", 64'(s_axi_arready), 64'(0));
        check("rst_rvalid", 64'(s_axi_rvalid), 64'(0));
        check("rst_rlast", 64'(s_axi_rlast), 64'(0));
        check("rst_rdata", 64'(s_axi_rdata), 64'(0));
        check("rst_ids", 64'({s_axi_bid, s_axi_rid, s_axi_bresp, s_axi_rresp}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_awready", 64'(s_axi_awready), 64'(1));
        check("idle_arready", 64'(s_axi_arready), 64'(1));

        // Single write/read
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(8'h5A, 32'h10, 0, 2, 1, 1'b0, 0);
        do_read(8'h33, 32'h10, 0, 2, 1, 0);
        check("single_rdata", 64'(got[0]), 64'(32'hDEADBEEF));

        // INCR burst, toggling then continuous rready
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(8'h01, 32'h100, 3, 2, 1, 1'b0, 0);
        do_read(8'h02, 32'h100, 3, 2, 1, 1);
        for (int i = 0; i < 4; i++) check("incr_toggle_data", 64'(got[i]), 64'(i + 1));
        do_read(8'h03, 32'h100, 3, 2, 1, 0);
        for (int i = 0; i < 4; i++) check("incr_stream_data", 64'(got[i]), 64'(i + 1));

        // WRAP read from 0x38 over 0x30..0x3C
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        do_write(8'h04, 32'h30, 3, 2, 1, 1'b0, 0);
        do_read(8'h05, 32'h38, 3, 2, 2, 0);
        check("wrap_beat0", 64'(got[0]), 64'(32'hA2));
        check("wrap_beat1", 64'(got[1]), 64'(32'hA3));
        check("wrap_beat2", 64'(got[2]), 64'(32'hA0));
        check("wrap_beat3", 64'(got[3]), 64'(32'hA1));

        // FIXED write: last beat persists
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h11 * 32'(i + 1); ws[i] = 4'hF; end
        do_write(8'h06, 32'h40, 3, 2, 0, 1'b0, 0);
        do_read(8'h07, 32'h40, 0, 2, 1, 0);
        check("fixed_final", 64'(got[0]), 64'(32'h44));
        check("fixed_neighbor_untouched", 64'(model_mask(32'h44)), 64'(0));

        // Byte strobes
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        do_write(8'h08, 32'h80, 0, 2, 1, 1'b0, 0);
        wd[0] = 32'h12345678; ws[0] = 4'h5;
        do_write(8'h09, 32'h80, 0, 2, 1, 1'b0, 0);
        do_read(8'h0A, 32'h80, 0, 2, 1, 0);
        check("strobe_merge", 64'(got[0]), 64'(32'hFF34FF78));

        // Early wlast still consumes len+1 beats; long B stall
        wd[0] = 32'hCAFE0000; wd[1] = 32'hCAFE0001; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(8'h0B, 32'hC0, 1, 2, 1, 1'b1, 10);
        do_read(8'h0C, 32'hC0, 1, 2, 1, 2);
        check("early_wlast_beat1", 64'(got[1]), 64'(32'hCAFE0001));

        // Reset during beat 2 of a len=7 read
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(8'h0D, 32'h200, 7, 2, 1, 1'b0, 0);
        s_axi_arid = 8'h44; s_axi_araddr = 16'h200; s_axi_arlen = 8'd7;
        s_axi_arsize = 3'd2; s_axi_arburst = 2'd1; s_axi_arvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        check("mid_rst_rvalid_before", 64'(s_axi_rvalid), 64'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_rst_beat2", 64'(s_axi_rdata), 64'(wd[2]));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rvalid", 64'(s_axi_rvalid), 64'(0));
        check("async_rst_arready", 64'(s_axi_arready), 64'(0));
        check("async_rst_rlast", 64'(s_axi_rlast), 64'(0));
        s_axi_rready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_arready", 64'(s_axi_arready), 64'(1));
        check("post_rst_awready", 64'(s_axi_awready), 64'(1));
        do_read(8'h45, 32'h200, 7, 2, 1, 0);
        for (int i = 0; i < 8; i++) check("post_rst_read", 64'(got[i]), 64'(wd[i]));

        // Randomized bursts, all burst types and sizes, random backpressure
        for (int n = 0; n < 12; n++) begin
            sz = $urandom_range(0, 2);
            bu = $urandom_range(0, 3);
            ln = (bu == 2) ? ((1 << $urandom_range(1, 3)) - 1) : $urandom_range(0, 7);
            a  = 32'h1000 + (32'($urandom_range(0, 1023)) & ~((32'd1 << sz) - 32'd1));
            for (int i = 0; i <= ln; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            do_write(8'($urandom), a, ln, sz, bu, 1'b0, $urandom_range(0, 3));
            do_read(8'($urandom), a, ln, sz, bu, 2);
        end

        // Spot-check a fully written word outside any burst path
        m = model_mask(32'h100);
        check("model_word_100", 64'(model_word(32'h100) & m), 64'(32'h1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
